// File: rtl/pb_key_encoder.sv
// pb_key_encoder: synchronised, priority-encoded 16-button key encoder with press strobe and count.
// Define PB_KEY_DEBOUNCE_EN to add press/release hold-time qualification of DEBOUNCE_CYCLES.
module pb_key_encoder #(
    parameter int DEBOUNCE_CYCLES = 5
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic [15:0] pb,
    output logic [3:0]  code,
    output logic        valid,
    output logic        strobe,
    output logic [7:0]  press_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        PRESSED = 2'd2,
        RELQ    = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] s1;
    logic [15:0] s2;
    logic        any;
    logic [3:0]  enc;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
        $error("pb_key_encoder: DEBOUNCE_CYCLES must be in 1..255");
    end

    always_ff @(posedge hz100) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pb;
            s2 <= s1;
        end
    end

    // Ascending scan: the highest set bit is the last one written.
    always_comb begin
        any = |s2;
        enc = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (s2[i]) enc = 4'(i);
        end
    end

    assign valid = (state == PRESSED) || (state == RELQ);

`ifdef PB_KEY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [3:0]    cand;

    always_ff @(posedge hz100) begin
        if (!reset) begin
            state       <= IDLE;
            code        <= '0;
            strobe      <= 1'b0;
            press_count <= '0;
            cnt         <= '0;
            cand        <= '0;
        end else begin
            strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        state <= QUAL;
                        cand  <= enc;
                        cnt   <= '0;
                    end
                end
                QUAL: begin
                    if (!any || enc != cand) begin
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        state       <= PRESSED;
                        code        <= cand;
                        strobe      <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    // Key changes while held are ignored: no rollover.
                    if (!any) begin
                        state <= RELQ;
                        cnt   <= '0;
                    end
                end
                RELQ: begin
                    if (any) begin
                        state <= PRESSED;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge hz100) begin
        if (!reset) begin
            state       <= IDLE;
            code        <= '0;
            strobe      <= 1'b0;
            press_count <= '0;
        end else begin
            strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        state       <= PRESSED;
                        code        <= enc;
                        strobe      <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end
                end
                PRESSED: begin
                    if (!any) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_pb_key_encoder.sv
// Scoreboard bench for pb_key_encoder: stimulus queues expected strobes, a monitor checks them.
module tb_pb_key_encoder;

    localparam int D = 5;
`ifdef PB_KEY_DEBOUNCE_EN
    localparam int WAITC = D;
`else
    localparam int WAITC = 0;
`endif
    // Edges from s1 capture to strobe: two synchroniser edges plus qualification.
    localparam int LAT = 2 + WAITC;

    logic        hz100;
    logic        reset;
    logic [15:0] pb;
    logic [3:0]  code;
    logic        valid;
    logic        strobe;
    logic [7:0]  press_count;

    pb_key_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .hz100      (hz100),
        .reset      (reset),
        .pb         (pb),
        .code       (code),
        .valid      (valid),
        .strobe     (strobe),
        .press_count(press_count)
    );

    typedef struct {
        logic [3:0] code;
        logic [7:0] count;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks      = 0;
    int   failures    = 0;
    int   cyc         = 0;
    int   strobes     = 0;
    int   exp_count   = 0;
    logic prev_strobe = 1'b0;

    initial begin
        hz100 = 1'b0;
        forever #5 hz100 = ~hz100;
    end

    always @(posedge hz100) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge hz100);
    endtask

    // Drive one key at a negedge; the next posedge is t0.
    task automatic press_key(input int idx, input int hold, input int idle);
        exp_t e;
        pb = '0;
        pb[idx] = 1'b1;
        exp_count++;
        e.code  = 4'(idx);
        e.count = 8'(exp_count);
        e.cyc   = cyc + 1 + LAT;
        q.push_back(e);
        tick(hold);
        pb = '0;
        tick(idle);
    endtask

    always @(negedge hz100) begin
        if (strobe) begin
            strobes++;
            check("strobe_single_cycle", 32'(prev_strobe), 32'd0);
            if (q.size() == 0) begin
                check("strobe_expected", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("strobe_cycle", cyc, mon_e.cyc);
                check("strobe_code", 32'(code), 32'(mon_e.code));
                check("strobe_count", 32'(press_count), 32'(mon_e.count));
                check("strobe_valid", 32'(valid), 32'd1);
            end
        end
        prev_strobe = strobe;
    end

    initial begin
        exp_t e;
        int   rel;
        int   base;
        reset = 1'b0;
        pb    = 16'hFFFF;
        tick(1);

        // Reset held with every button pressed.
        for (int i = 0; i < 3; i++) begin
            check("reset_outputs", 32'({code, valid, strobe, press_count}), 32'd0);
            tick(1);
        end
        pb    = '0;
        reset = 1'b1;
        tick(4);
        check("post_reset_idle", 32'({code, valid, press_count}), 32'd0);

        // Clean press of bit 9, then release timing of valid.
        press_key(9, 20, 0);
        rel = cyc + 1;
        check("clean_code", 32'(code), 32'h9);
        check("clean_count", 32'(press_count), 32'd1);
        tick(LAT);
        check("valid_before_release_done", 32'(valid), 32'd1);
        tick(1);
        check("valid_after_release_done", 32'(valid), 32'd0);
        check("release_cycle_ref", cyc, rel + LAT);
        check("code_held_after_release", 32'(code), 32'h9);
        tick(4);

        // Priority: bits 2 and 4 together, then bounce bit 4 while bit 2 holds.
        pb = 16'h0014;
        exp_count++;
        e.code  = 4'h4;
        e.count = 8'(exp_count);
        e.cyc   = cyc + 1 + LAT;
        q.push_back(e);
        tick(20);
        check("priority_code", 32'(code), 32'h4);
        for (int i = 0; i < 5; i++) begin
            pb = pb ^ 16'h0010;
            tick(2);
        end
        check("bounce_count", 32'(press_count), 32'(8'(exp_count)));
        check("bounce_code", 32'(code), 32'h4);
        check("bounce_valid", 32'(valid), 32'd1);
        pb = '0;
        tick(LAT + 4);
        check("bounce_released", 32'(valid), 32'd0);

        // Three-cycle glitch on bit 3.
`ifdef PB_KEY_DEBOUNCE_EN
        pb = 16'h0008;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("glitch_valid_low", 32'(valid), 32'd0);
        end
        pb = '0;
        for (int i = 0; i < LAT + 2; i++) begin
            tick(1);
            check("glitch_valid_low", 32'(valid), 32'd0);
        end
        check("glitch_code_kept", 32'(code), 32'h4);
        check("glitch_count_kept", 32'(press_count), 32'(8'(exp_count)));
`else
        // Without qualification a three-cycle press is a real press.
        press_key(3, 3, LAT + 4);
        check("glitch_code_taken", 32'(code), 32'h3);
        check("glitch_valid_low", 32'(valid), 32'd0);
`endif
        tick(4);

        // Wrap: 256 presses from a freshly reset count.
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        exp_count = 0;
        tick(3);
        check("wrap_start", 32'(press_count), 32'd0);
        base = strobes;
        for (int i = 0; i < 256; i++) begin
            press_key(0, 10, 10);
        end
        check("wrap_count", 32'(press_count), 32'd0);
        check("wrap_strobes", strobes - base, 32'd256);

        // Reset while bit 7 is held in PRESSED, then re-qualification.
        pb = 16'h0080;
        exp_count++;
        e.code  = 4'h7;
        e.count = 8'(exp_count);
        e.cyc   = cyc + 1 + LAT;
        q.push_back(e);
        tick(LAT + 3);
        check("midpress_valid", 32'(valid), 32'd1);
        check("midpress_code", 32'(code), 32'h7);
        reset = 1'b0;
        tick(1);
        check("midpress_reset_outputs", 32'({code, valid, strobe, press_count}), 32'd0);
        reset = 1'b1;
        exp_count = 1;
        e.code  = 4'h7;
        e.count = 8'd1;
        e.cyc   = cyc + 1 + LAT;
        q.push_back(e);
        tick(LAT + 3);
        check("requal_valid", 32'(valid), 32'd1);
        check("requal_code", 32'(code), 32'h7);
        check("requal_count", 32'(press_count), 32'd1);
        pb = '0;
        tick(LAT + 4);
        check("requal_released", 32'(valid), 32'd0);

        tick(5);
        check("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
